// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter sharing one host SD block port between NREQ requesters.
// Optional request watchdog: define IEEEDRV_SD_ARB_TIMEOUT_EN.
module ieeedrv_sd_arb #(
    parameter int          NREQ    = 2,
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [NREQ*32-1:0]   req_lba,
    input  logic [NREQ*6-1:0]    req_blk_cnt,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_err,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [RW-1:0]     r_rr;
    logic [RW-1:0]     r_win;
    logic              r_op_wr;
    logic [NREQ-1:0]   r_grant;
    logic [31:0]       r_lba;
    logic [5:0]        r_blk_cnt;
    logic              r_sd_rd;
    logic              r_sd_wr;

    logic [NREQ-1:0]   w_pend;
    logic [31:0]       w_lba [NREQ];
    logic [5:0]        w_cnt [NREQ];
    logic              w_found;
    logic [RW-1:0]     w_win;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_pend[gi]  = req_rd[gi] | req_wr[gi];
            assign w_lba[gi]   = req_lba[gi*32 +: 32];
            assign w_cnt[gi]   = req_blk_cnt[gi*6 +: 6];
            assign req_ack[gi] = sd_ack & r_grant[gi];
        end
    endgenerate

    // First pending requester strictly after the last winner, wrapping.
    always_comb begin
        int            v_idx;
        logic [RW-1:0] v_sel;
        w_found = 1'b0;
        w_win   = r_rr;
        v_idx   = 0;
        v_sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = int'(r_rr) + k;
            if (v_idx >= NREQ)
                v_idx = v_idx - NREQ;
            v_sel = RW'(v_idx);
            if (!w_found && w_pend[v_sel]) begin
                w_found = 1'b1;
                w_win   = v_sel;
            end
        end
    end

`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
    logic [23:0]     r_to_cnt;
    logic [NREQ-1:0] r_err;
    assign req_err = r_err;
`else
    // TIMEOUT is inert without the watchdog; no abort path exists.
    localparam logic [NREQ-1:0] ERR_NONE = (TIMEOUT == 24'd0) ? '0 : '0;
    assign req_err = ERR_NONE;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_rr      <= RW'(NREQ - 1);
            r_win     <= '0;
            r_op_wr   <= 1'b0;
            r_grant   <= '0;
            r_lba     <= '0;
            r_blk_cnt <= '0;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_err     <= '0;
`endif
        end else begin
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
            r_err <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_REQ;
                        r_win     <= w_win;
                        r_rr      <= w_win;
                        r_grant   <= NREQ'(1) << w_win;
                        r_lba     <= w_lba[w_win];
                        r_blk_cnt <= w_cnt[w_win];
                        r_op_wr   <= req_wr[w_win];
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (sd_ack) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= S_XFER;
                    end else if (!w_pend[r_win]) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TIMEOUT) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_err   <= r_grant;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
`endif
                    else begin
                        r_sd_rd <= ~r_op_wr;
                        r_sd_wr <= r_op_wr;
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
                        r_to_cnt <= r_to_cnt + 24'd1;
`endif
                    end
                end
                S_XFER: begin
                    if (!sd_ack)
                        r_state <= S_GAP;
                end
                S_GAP: begin
                    // Grant survived one cycle past the ack fall; release now.
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign sd_lba     = r_lba;
    assign sd_blk_cnt = r_blk_cnt;
    assign sd_rd      = r_sd_rd;
    assign sd_wr      = r_sd_wr;

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Randomized bench for ieeedrv_sd_arb against a transaction-level round-robin model.
module tb_ieeedrv_sd_arb;

    localparam int N = 2;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [N*32-1:0]   req_lba = '0;
    logic [N*6-1:0]    req_blk_cnt = '0;
    logic [N-1:0]      req_rd = '0;
    logic [N-1:0]      req_wr = '0;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      req_err;
    logic [N-1:0]      grant;
    logic              busy;
    logic [31:0]       sd_lba;
    logic [5:0]        sd_blk_cnt;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack = 1'b0;

    ieeedrv_sd_arb #(.NREQ(N), .TIMEOUT(24'd100)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .req_lba    (req_lba),
        .req_blk_cnt(req_blk_cnt),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_ack    (req_ack),
        .req_err    (req_err),
        .grant      (grant),
        .busy       (busy),
        .sd_lba     (sd_lba),
        .sd_blk_cnt (sd_blk_cnt),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: last winner plus what each requester is asking for.
    int          m_rr;
    bit          m_pend [N];
    logic [31:0] m_lba  [N];
    logic [5:0]  m_cnt  [N];
    bit          m_wr   [N];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic raise(input int i, input bit rd, input bit wr,
                         input logic [31:0] lba, input logic [5:0] cnt);
        req_rd[i] = rd;
        req_wr[i] = wr;
        req_lba[i*32 +: 32]   = lba;
        req_blk_cnt[i*6 +: 6] = cnt;
        m_pend[i] = 1'b1;
        m_lba[i]  = lba;
        m_cnt[i]  = cnt;
        m_wr[i]   = wr;
    endtask

    task automatic drop(input int i);
        req_rd[i] = 1'b0;
        req_wr[i] = 1'b0;
        m_pend[i] = 1'b0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (m_pend[idx])
                return idx;
        end
        return -1;
    endfunction

    task automatic raise_rand(input int i);
        int op;
        op = int'($urandom_range(0, 2));
        raise(i, op != 1, op != 0, $urandom, 6'($urandom));
    endtask

    // One arbitration round for expected winner w, as seen from the host side.
    task automatic serve(input int w, input bit cancel, input int dly, input int len);
        int          n;
        logic [31:0] e_lba;
        logic [5:0]  e_cnt;
        bit          e_wr;
        n = 0;
        while (grant == '0 && n < 16) begin
            tick();
            n++;
        end
        chk("grant_wait", grant != '0, 1);
        if (grant == '0)
            return;
        chk("grant", grant, 1 << w);
        chk("strobe_early", {sd_rd, sd_wr}, 0);
        chk("busy", busy, 1);
        e_lba = m_lba[w];
        e_cnt = m_cnt[w];
        e_wr  = m_wr[w];
        req_lba[w*32 +: 32]   = $urandom;
        req_blk_cnt[w*6 +: 6] = 6'($urandom);
        tick();
        chk("sd_lba", sd_lba, e_lba);
        chk("sd_blk_cnt", sd_blk_cnt, e_cnt);
        chk("strobe", {sd_rd, sd_wr}, {~e_wr, e_wr});
        m_rr = w;
        if (cancel) begin
            drop(w);
            tick();
            chk("cancel_grant", grant, 0);
            chk("cancel_strobe", {sd_rd, sd_wr}, 0);
            if (pick() < 0) begin
                sd_ack = 1'b1;
                #1 chk("stray_ack", req_ack, 0);
                tick();
                chk("stray_ack_grant", grant, 0);
                sd_ack = 1'b0;
            end
            $display("txn req=%0d lba=%08h cnt=%0d wr=%0d cancelled", w, e_lba, e_cnt, e_wr);
            return;
        end
        for (int d = 0; d < dly; d++) begin
            tick();
            chk("strobe_hold", sd_rd | sd_wr, 1);
        end
        sd_ack = 1'b1;
        #1 chk("ack_route", req_ack, 1 << w);
        tick();
        chk("strobe_drop", {sd_rd, sd_wr}, 0);
        chk("ack_route_xfer", req_ack, 1 << w);
        drop(w);
        for (int l = 1; l < len; l++) begin
            tick();
            chk("ack_hold", req_ack, 1 << w);
        end
        sd_ack = 1'b0;
        #1 chk("ack_fall", req_ack, 0);
        tick();
        chk("gap_grant", grant, 1 << w);
        tick();
        chk("release_grant", grant, 0);
        chk("release_busy", busy, 0);
        $display("txn req=%0d lba=%08h cnt=%0d wr=%0d dly=%0d len=%0d", w, e_lba, e_cnt, e_wr, dly, len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_rr = N - 1;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", {sd_rd, sd_wr}, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_cnt", sd_blk_cnt, 0);
        chk("rst_err", req_err, 0);
        reset_n = 1'b1;
        tick();

        // Single read with long ack.
        raise(0, 1'b1, 1'b0, 32'h1D, 6'd28);
        serve(pick(), 1'b0, 5, 40);

        // Contention then sustained alternation.
        raise(0, 1'b1, 1'b0, $urandom, 6'($urandom));
        raise(1, 1'b0, 1'b1, $urandom, 6'($urandom));
        for (int r = 0; r < 4; r++) begin
            int w;
            w = pick();
            serve(w, 1'b0, 1, 2);
            raise_rand(w);
        end
        while (pick() >= 0) serve(pick(), 1'b0, 0, 1);

        // Read and write together: write wins.
        raise(1, 1'b1, 1'b1, $urandom, 6'($urandom));
        serve(pick(), 1'b0, 2, 3);

        // Cancel before ack.
        raise(0, 1'b1, 1'b0, $urandom, 6'($urandom));
        serve(pick(), 1'b1, 0, 1);

        // Randomized rounds.
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < N; i++)
                if (!m_pend[i] && $urandom_range(0, 1) == 1) raise_rand(i);
            if (pick() < 0) raise_rand(int'($urandom_range(0, N - 1)));
            serve(pick(), $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 4)), int'($urandom_range(1, 6)));
        end
        while (pick() >= 0) serve(pick(), 1'b0, 0, 1);

        // Asynchronous reset during a transfer.
        raise(0, 1'b1, 1'b0, $urandom, 6'($urandom));
        n = 0;
        while (grant == '0 && n < 16) begin
            tick();
            n++;
        end
        tick();
        sd_ack = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("arst_strobe", {sd_rd, sd_wr}, 0);
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ack", req_ack, 0);
        drop(0);
        raise(1, 1'b1, 1'b0, $urandom, 6'($urandom));
        tick();
        sd_ack = 1'b0;
        reset_n = 1'b1;
        m_rr = N - 1;
        serve(pick(), 1'b0, 1, 2);

`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
        // Host never acks: watchdog aborts after TIMEOUT strobe cycles.
        raise(0, 1'b1, 1'b0, $urandom, 6'($urandom));
        raise(1, 1'b1, 1'b0, $urandom, 6'($urandom));
        n = 0;
        while (grant == '0 && n < 16) begin
            tick();
            n++;
        end
        chk("to_grant", grant, 1);
        tick();
        n = 0;
        while (sd_rd && n < 300) begin
            n++;
            tick();
        end
        chk("to_len", n, 100);
        chk("to_err", req_err, 1);
        chk("to_release", grant, 0);
        m_rr = 0;
        tick();
        chk("to_err_pulse", req_err, 0);
        drop(0);
        serve(pick(), 1'b0, 1, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ieeedrv_sd_arb.md
Name: ieeedrv_sd_arb

Overview:
- Round-robin arbiter sharing the single MiSTer SD block interface between NREQ track loaders/savers (sub-drives or drive units).
- Each requester presents LBA, block count and a rd/wr strobe, and holds it until acknowledged.
- The arbiter latches the winner's command, drives the host SD port, routes `sd_ack` back to the winner only, and exposes a one-hot grant for sector-buffer muxing.

Parameters:
- NREQ, 2, number of requesters (1..8).
- TIMEOUT, 24'hFFFFFF, clk_sys cycles to wait for `sd_ack` before abort (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_lba  in  32 x NREQ  per-requester start LBA.
- req_blk_cnt  in  6 x NREQ  per-requester block count minus 1.
- req_rd  in  NREQ  read request, level, held until ack.
- req_wr  in  NREQ  write request, level, held until ack.
- req_ack  out  NREQ  `sd_ack` mirrored to the granted requester.
- req_err  out  NREQ  one-cycle abort pulse to the granted requester.
- grant  out  NREQ  one-hot current owner, 0 when idle.
- busy  out  1  arbiter not in IDLE.
- sd_lba  out  32  host LBA.
- sd_blk_cnt  out  6  host block count.
- sd_rd  out  1  host read strobe.
- sd_wr  out  1  host write strobe.
- sd_ack  in  1  host acknowledge, synchronous to clk_sys.

Behaviour:
- Reset (async, reset_n=0): state IDLE; sd_rd, sd_wr, grant, req_err, busy = 0; sd_lba = 0; sd_blk_cnt = 0; rr pointer = NREQ-1.
- Request vector: `pend[i] = req_rd[i] | req_wr[i]`.
- IDLE:
  - If `pend != 0`, pick the first set bit searching upward from rr+1, wrapping modulo NREQ.
  - Latch that requester's lba, blk_cnt and op into sd_lba/sd_blk_cnt. If both rd and wr are set, wr wins.
  - Set grant, set rr = winner, go to REQ. Latency request -> grant = 1 cycle.
- REQ:
  - sd_rd or sd_wr = 1 (registered, one cycle after grant).
  - sd_lba/sd_blk_cnt are stable for the whole grant; later changes on req_* are ignored.
  - Exit 1: `sd_ack=1` -> clear both strobes (same edge), go to XFER.
  - Exit 2: `sd_ack=0` and `pend[winner]` dropped -> cancel. Clear strobes and grant, go to IDLE.
- XFER:
  - No cancel. Requester request lines are ignored.
  - On `sd_ack` falling (sampled 0) -> go to GAP.
- GAP:
  - One cycle. Grant is still held so the requester sees the ack falling edge with grant valid.
  - Then grant = 0, go to IDLE.
  - Minimum 2 idle-to-strobe cycles between transfers.
- req_ack[i] = sd_ack & grant[i], combinational (zero latency). A non-granted requester never sees ack.
- busy = (state != IDLE).
- Fairness: after a grant to i, requester i has lowest priority next round. No requester waits more than NREQ-1 transfers.
- Simultaneous events: a new request arriving during REQ/XFER/GAP stays pending and is evaluated in IDLE only.
- NREQ=1: rr logic degenerates; behaviour is otherwise identical.
- reset_n low mid-transfer: outputs drop immediately. The host may still complete its ack; the arbiter ignores `sd_ack` while in IDLE.

Optional Feature:
- Macro: IEEEDRV_SD_ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT with no ack: clear strobes, pulse req_err[winner] for 1 cycle, release grant, go to IDLE.
  - rr advances normally.
- Not defined: no counter; REQ waits indefinitely; req_err is tied 0.

Test Plan:
1. Single read: req_rd[0]=1, lba 0x1D, cnt 28.
   - Response: grant=01 next cycle; sd_rd=1 with sd_lba=0x1D, sd_blk_cnt=28 one cycle later.
   - Host acks 5 cycles later for 40 cycles: sd_rd drops on the ack edge; req_ack[0] tracks sd_ack exactly; req_ack[1]=0; grant clears 1 cycle after ack falls.
2. Contention: req_rd[0] and req_wr[1] both raised in the same cycle with rr reset.
   - Response: grant order 0 then 1; the second sd_wr carries requester 1's lba.
   - Repeat with both continuously pending: grants alternate 0,1,0,1.
3. rd+wr both set on requester 1 -> sd_wr=1, sd_rd=0.
4. Cancel: req_rd[0] dropped in REQ before ack -> sd_rd=0 and grant=0 next cycle; a later ack pulse yields req_ack=0.
5. Async reset asserted during XFER -> sd_rd/sd_wr/grant/busy = 0 immediately; after release, a pending req_rd[1] is granted normally.
6. IEEEDRV_SD_ARB_TIMEOUT_EN with TIMEOUT=100, host never acks.
   - Response: sd_rd held 100 cycles, then dropped; req_err[0] pulses once; arbiter returns to IDLE and serves requester 1 next.
